mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback stage of the pipelined RV32I core. It captures the memory-stage result every cycle and extracts and sign- or zero-extends load data. It selects the writeback value and drives the register file write port (RFWr, A3, WD) directly. The register file bypasses WD to its read ports when A3 matches, so WD is produced combinationally from this block's registered state with no extra latency.

---
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline register and writeback stage (RV32I core).
//
// Captures the memory-stage result each cycle, extracts and sign/zero-extends
// load data from the registered data word, selects the writeback value and
// drives the register-file write port. WD/A3/wb_* are pure functions of the
// registered state; hold only gates RFWr combinationally.
//
// Optional feature: define WB_INSTRET_EN to build a 64-bit retired-instruction
// counter on instret; otherwise instret is tied to zero.
//
// Ports:
//   clk, rst           core clock; synchronous active-low reset
//   m_valid .. m_dmem_rdata   MEM-stage instruction fields
//   flush              kill the instruction entering WB (wins over hold)
//   hold               freeze WB and suppress the write
//   RFWr, A3, WD       register file write port
//   wb_valid, wb_pc    status of the instruction in WB
//   instret            retired-instruction count
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  input  logic            m_regwrite,
  input  logic [4:0]      m_rd,
  input  logic [1:0]      m_wdsel,
  input  logic [2:0]      m_ldtype,
  input  logic [XLEN-1:0] m_alu_res,
  input  logic [XLEN-1:0] m_pc,
  input  logic [XLEN-1:0] m_dmem_rdata,
  input  logic            flush,
  input  logic            hold,
  output logic            RFWr,
  output logic [4:0]      A3,
  output logic [XLEN-1:0] WD,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic [63:0]     instret
);

  logic            valid_reg;
  logic            regwrite_reg;
  logic [4:0]      rd_reg;
  logic [1:0]      wdsel_reg;
  logic [2:0]      ldtype_reg;
  logic [1:0]      addr_lo_reg;
  logic [XLEN-1:0] alu_res_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] rdata_reg;

  // Priority: reset, flush, hold, load. Flush only needs to clear valid;
  // the remaining fields are don't-care once the slot is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      rd_reg       <= '0;
      wdsel_reg    <= '0;
      ldtype_reg   <= '0;
      addr_lo_reg  <= '0;
      alu_res_reg  <= '0;
      pc_reg       <= '0;
      rdata_reg    <= '0;
    end else if (flush) begin
      valid_reg    <= 1'b0;
    end else if (!hold) begin
      valid_reg    <= m_valid;
      regwrite_reg <= m_regwrite;
      rd_reg       <= m_rd;
      wdsel_reg    <= m_wdsel;
      ldtype_reg   <= m_ldtype;
      addr_lo_reg  <= m_alu_res[1:0];
      alu_res_reg  <= m_alu_res;
      pc_reg       <= m_pc;
      rdata_reg    <= m_dmem_rdata;
    end
  end

  // Byte lanes of the registered data word.
  logic [7:0] byte_lane [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata_reg[8*gi +: 8];
    end
  endgenerate

  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] pc_plus4;

  // Halfword lane uses addr_lo[1] only; misaligned addr_lo[0] is ignored.
  assign sel_byte = byte_lane[addr_lo_reg];
  assign sel_half = addr_lo_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
  assign pc_plus4 = pc_reg + XLEN'(4);

  always_comb begin
    load_data = rdata_reg;
    case (ldtype_reg)
      3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
      default: load_data = rdata_reg;  // lw and undefined encodings
    endcase
  end

  always_comb begin
    WD = alu_res_reg;
    case (wdsel_reg)
      2'b01:   WD = load_data;
      2'b10:   WD = pc_plus4;
      default: WD = alu_res_reg;
    endcase
  end

  // An instruction commits in its first WB cycle with hold low; the register
  // file writes on the following edge.
  assign RFWr     = valid_reg & regwrite_reg & (rd_reg != 5'd0) & ~hold;
  assign A3       = rd_reg;
  assign wb_valid = valid_reg;
  assign wb_pc    = pc_reg;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_reg;

  // Counts every retirement regardless of regwrite/rd; flush does not clear it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_reg <= '0;
    end else if (valid_reg && !hold) begin
      instret_reg <= instret_reg + 64'd1;
    end
  end

  assign instret = instret_reg;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_regwrite;
  logic [4:0]  m_rd;
  logic [1:0]  m_wdsel;
  logic [2:0]  m_ldtype;
  logic [31:0] m_alu_res, m_pc, m_dmem_rdata;
  logic        flush, hold;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [63:0] instret;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_regwrite(m_regwrite), .m_rd(m_rd),
    .m_wdsel(m_wdsel), .m_ldtype(m_ldtype), .m_alu_res(m_alu_res),
    .m_pc(m_pc), .m_dmem_rdata(m_dmem_rdata),
    .flush(flush), .hold(hold),
    .RFWr(RFWr), .A3(A3), .WD(WD),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .instret(instret)
  );

  // Reference model: contents of the WB slot plus retired count.
  bit          e_valid, e_regwrite;
  int unsigned e_rd, e_wdsel, e_ldtype, e_addr;
  logic [31:0] e_alu, e_pc, e_rdata;
  longint unsigned e_cnt = 0;

  function automatic logic [31:0] ref_wd();
    int unsigned b, h;
    b = (e_rdata >> (8 * e_addr)) & 32'hFF;
    h = (e_rdata >> (16 * (e_addr / 2))) & 32'hFFFF;
    if (e_wdsel == 2) return e_pc + 32'd4;
    if (e_wdsel != 1) return e_alu;
    case (e_ldtype)
      0:       return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      1:       return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      4:       return 32'(b);
      5:       return 32'(h);
      default: return e_rdata;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit exp_rfwr;
    exp_rfwr = e_valid && e_regwrite && (e_rd != 0) && !hold;
    chk("RFWr", 64'(RFWr), 64'(exp_rfwr));
    chk("A3", 64'(A3), 64'(e_rd));
    chk("WD", 64'(WD), 64'(ref_wd()));
    chk("wb_valid", 64'(wb_valid), 64'(e_valid));
    chk("wb_pc", 64'(wb_pc), 64'(e_pc));
`ifdef WB_INSTRET_EN
    chk("instret", instret, 64'(e_cnt));
`else
    chk("instret", instret, 64'd0);
`endif
  endtask

  task automatic model_edge();
    if (!rst) e_cnt = 0;
    else if (e_valid && !hold) e_cnt = e_cnt + 1;
    if (!rst) begin
      e_valid = 0; e_regwrite = 0; e_rd = 0; e_wdsel = 0; e_ldtype = 0;
      e_addr = 0; e_alu = 0; e_pc = 0; e_rdata = 0;
    end else if (flush) begin
      e_valid = 0;
    end else if (!hold) begin
      e_valid = m_valid; e_regwrite = m_regwrite; e_rd = m_rd;
      e_wdsel = m_wdsel; e_ldtype = m_ldtype; e_addr = m_alu_res % 4;
      e_alu = m_alu_res; e_pc = m_pc; e_rdata = m_dmem_rdata;
    end
  endtask

  // Check the current cycle, then advance one edge and update the model.
  task automatic cycle();
    #1;
    check_all();
    $display("t=%0t rst=%0b flush=%0b hold=%0b RFWr=%0b A3=%0d WD=%08h wb_valid=%0b wb_pc=%08h instret=%0d",
             $time, rst, flush, hold, RFWr, A3, WD, wb_valid, wb_pc, instret);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] ws,
                        input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] rdata);
    m_valid = v; m_regwrite = rw; m_rd = rd; m_wdsel = ws; m_ldtype = lt;
    m_alu_res = alu; m_pc = pc; m_dmem_rdata = rdata;
  endtask

  initial begin
    logic [2:0]  ld_t   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_a   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF81, 32'h0000_007F, 32'hFFFF_80F0,
                                32'h0000_80F0, 32'h80F0_7F81};
    longint unsigned cnt_before;

    // Reset with a valid instruction presented.
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    set_in(1, 1, 5'd9, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h100, 32'h0);
    @(posedge clk); model_edge(); #1;
    cycle();
    chk("reset_RFWr", 64'(RFWr), 64'd0);
    chk("reset_WD", 64'(WD), 64'd0);
    chk("reset_instret", instret, 64'd0);
    rst = 1'b1;
    cycle();
    chk("first_write_RFWr", 64'(RFWr), 64'd1);
    chk("first_write_A3", 64'(A3), 64'd9);

    // Load extraction.
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 5'(i + 10), 2'b01, ld_t[i], {30'h1000, ld_a[i]}, 32'h200, 32'h80F0_7F81);
      cycle();
      chk("load_WD", 64'(WD), 64'(ld_exp[i]));
    end

    // JAL at top of address space: pc+4 wraps.
    set_in(1, 1, 5'd1, 2'b10, 3'b000, 32'h5, 32'hFFFF_FFFC, 32'h0);
    cycle();
    chk("jal_WD", 64'(WD), 64'd0);
    chk("jal_RFWr", 64'(RFWr), 64'd1);
    chk("jal_A3", 64'(A3), 64'd1);

    // x0 destination, then regwrite=0.
    set_in(1, 1, 5'd0, 2'b00, 3'b000, 32'h77, 32'h300, 32'h0);
    cycle();
    chk("x0_RFWr", 64'(RFWr), 64'd0);
    set_in(1, 0, 5'd5, 2'b00, 3'b000, 32'h78, 32'h304, 32'h0);
    cycle();
    chk("norw_RFWr", 64'(RFWr), 64'd0);

    // Hold for three cycles, then release: exactly one write.
    set_in(1, 1, 5'd7, 2'b00, 3'b000, 32'h1234, 32'h400, 32'h0);
    cycle();
    cnt_before = instret;
    set_in(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_RFWr", 64'(RFWr), 64'd0);
      chk("hold_WD", 64'(WD), 64'h1234);
    end
    hold = 1'b0;
    #1;
    chk("release_RFWr", 64'(RFWr), 64'd1);
    cycle();
    chk("after_release_RFWr", 64'(RFWr), 64'd0);
`ifdef WB_INSTRET_EN
    chk("release_instret", instret, cnt_before + 64'd1);
`endif

    // Flush together with hold empties WB.
    set_in(1, 1, 5'd8, 2'b00, 3'b000, 32'h55, 32'h500, 32'h0);
    cycle();
    hold = 1'b1; flush = 1'b1;
    cycle();
    hold = 1'b0; flush = 1'b0;
    set_in(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    #1;
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_RFWr", 64'(RFWr), 64'd0);

    // Streaming to the same rd.
    cnt_before = instret;
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 1, 5'd3, 2'b00, 3'b000, 32'(i), 32'(32'h600 + 4 * i), 32'h0);
      cycle();
      chk("stream_RFWr", 64'(RFWr), 64'd1);
      chk("stream_WD", 64'(WD), 64'(i));
    end
    set_in(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    cycle();
`ifdef WB_INSTRET_EN
    chk("stream_instret", instret, cnt_before + 64'd4);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      cycle();
    end
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
